// File: rtl/lp_pkg.sv
// Shared types and constants for the LP simplex engine datapath controllers.
package lp_pkg;

  localparam int unsigned DATAW = 32;
  localparam int unsigned IDXW  = 16;

  localparam logic [31:0] FP32_ABS_MASK = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STREAM,
    DRAIN,
    DONE,
    TERM
  } pivot_ctrl_state_t;

endpackage

// File: rtl/pivot_rd_fifo.sv
// Skid FIFO absorbing BRAM read returns; depth need not be a power of two.
module pivot_rd_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DW-1:0]                  push_data,
  input  logic                           pop,
  output logic [$clog2(DEPTH + 1)-1:0]   count,
  output logic [DW-1:0]                  head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/pivot_row_ctrl.sv
// Pivot-row divide sequencer: fetches the pivot row from BRAM, streams it to the datapath.
// Optional watchdog and wdog_trip port enabled by defining PIVOT_ROW_WATCHDOG_EN.
module pivot_row_ctrl #(
  parameter int unsigned DATAW  = lp_pkg::DATAW,
  parameter int unsigned IDXW   = lp_pkg::IDXW,
  parameter int unsigned ADDRW  = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [IDXW-1:0]  num_cols,
  input  logic [ADDRW-1:0] row_base,
  input  logic [DATAW-1:0] factor_in,
  output logic [DATAW-1:0] factor_out,
  output logic             bram_en,
  output logic [ADDRW-1:0] bram_addr,
  input  logic [DATAW-1:0] bram_rdata,
  output logic [DATAW-1:0] M_AXIS_PIVOTROW_TDATA,
  output logic             M_AXIS_PIVOTROW_TVALID,
  input  logic             M_AXIS_PIVOTROW_TREADY,
  input  logic             dp_wen,
  input  logic [IDXW-1:0]  dp_widx,
  input  logic             dp_terminate,
  output logic             busy,
  output logic             done,
  output logic             terminate
`ifdef PIVOT_ROW_WATCHDOG_EN
  ,
  output logic             wdog_trip
`endif
);

  import lp_pkg::*;

  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = $clog2(2 * DEPTH + 1);

  pivot_ctrl_state_t state_q, state_d;
  logic [IDXW-1:0]   num_cols_q, num_cols_d;
  logic [IDXW-1:0]   rd_idx_q, rd_idx_d;
  logic [IDXW-1:0]   sent_q, sent_d;
  logic [IDXW-1:0]   wen_count_q, wen_count_d;
  logic [ADDRW-1:0]  row_base_q, row_base_d;
  logic [DATAW-1:0]  factor_q, factor_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              done_q, done_d;
  logic              terminate_q, terminate_d;
  logic              busy_q, busy_d;

  logic [CW-1:0]     fifo_cnt;
  logic [DATAW-1:0]  fifo_head;
  logic [SW-1:0]     inflight_c;
  logic              run_c, issue_c, push_c, pop_c, flush_c, fault_c, last_hs_c;
  logic              wdog_fire_c;

  pivot_rd_fifo #(
    .DW    (DATAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush_c),
    .push      (push_c),
    .push_data (bram_rdata),
    .pop       (pop_c),
    .count     (fifo_cnt),
    .head      (fifo_head)
  );

  assign M_AXIS_PIVOTROW_TVALID = (fifo_cnt != '0);
  assign M_AXIS_PIVOTROW_TDATA  = fifo_head;

  // Read credit counts a same-cycle pop so a full-rate stream never stalls the BRAM.
  always_comb begin
    run_c      = (state_q == STREAM) || (state_q == DRAIN);
    pop_c      = M_AXIS_PIVOTROW_TVALID && M_AXIS_PIVOTROW_TREADY && (state_q == STREAM);
    last_hs_c  = pop_c && (sent_q == num_cols_q - IDXW'(1));
    inflight_c = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight_c = inflight_c + SW'(vld_q[i]);
    issue_c    = (state_q == STREAM) && (rd_idx_q < num_cols_q) &&
                 ((inflight_c + SW'(fifo_cnt) - SW'(pop_c)) < SW'(DEPTH));
    push_c     = (state_q == STREAM) && vld_q[RD_LAT-1];
    vld_d      = flush_c ? '0 : RD_LAT'({vld_q, issue_c});
    fault_c    = run_c && (dp_terminate || (dp_wen && (dp_widx != wen_count_q)) || wdog_fire_c);
  end

  assign bram_en   = issue_c;
  assign bram_addr = issue_c ? row_base_q + ADDRW'(rd_idx_q) : '0;

  always_comb begin
    state_d     = state_q;
    num_cols_d  = num_cols_q;
    row_base_d  = row_base_q;
    factor_d    = factor_q;
    terminate_d = terminate_q;
    rd_idx_d    = rd_idx_q + IDXW'(issue_c);
    sent_d      = sent_q + IDXW'(pop_c);
    wen_count_d = wen_count_q + IDXW'(dp_wen && run_c);
    case (state_q)
      IDLE: begin
        if (start) begin
          num_cols_d  = num_cols;
          row_base_d  = row_base;
          factor_d    = factor_in;
          terminate_d = 1'b0;
          rd_idx_d    = '0;
          sent_d      = '0;
          wen_count_d = '0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if ((factor_q & DATAW'(FP32_ABS_MASK)) == '0) state_d = TERM;
        else if (num_cols_q == '0)                    state_d = DONE;
        else                                          state_d = STREAM;
      end
      STREAM: begin
        if (fault_c)        state_d = TERM;
        else if (last_hs_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (fault_c)                         state_d = TERM;
        else if (wen_count_d == num_cols_q)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    flush_c = (state_d == TERM);
    if (state_d == TERM) terminate_d = 1'b1;
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      num_cols_q  <= '0;
      row_base_q  <= '0;
      factor_q    <= '0;
      rd_idx_q    <= '0;
      sent_q      <= '0;
      wen_count_q <= '0;
      vld_q       <= '0;
      done_q      <= 1'b0;
      terminate_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_cols_q  <= num_cols_d;
      row_base_q  <= row_base_d;
      factor_q    <= factor_d;
      rd_idx_q    <= rd_idx_d;
      sent_q      <= sent_d;
      wen_count_q <= wen_count_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      terminate_q <= terminate_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PIVOT_ROW_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        wdog_trip_q, wdog_trip_d;

  // Counts idle cycles while a row is in flight; any progress restarts it.
  assign wdog_fire_c = run_c && (wdog_q == 16'hFFFF);

  always_comb begin
    wdog_d      = '0;
    wdog_trip_d = wdog_trip_q;
    if (run_c && !(dp_wen || pop_c)) wdog_d = wdog_q + 16'd1;
    if ((state_q == IDLE) && start) wdog_trip_d = 1'b0;
    if (wdog_fire_c) wdog_trip_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdog_q      <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  assign wdog_fire_c = 1'b0;
`endif

  assign factor_out = factor_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign terminate  = terminate_q;

endmodule
